// File: rtl/delay_line_arbiter.sv
// Round-robin arbiter sharing one fixed-latency delay line between two requesters; results return NUM_DELAY cycles after accept.
// Ready is granted combinationally to at most one requester; no output backpressure, consumers take each beat in its cycle.
module delay_line_arbiter #(
  parameter int N         = 32,
  parameter int NUM_DELAY = 5,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [N-1:0] req0_data,
  input  logic         req0_last,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [N-1:0] req1_data,
  input  logic         req1_last,
  output logic         req1_ready,
  output logic [N-1:0] dl_in,
  input  logic [N-1:0] dl_out,
  output logic [N-1:0] out_data,
  output logic         out0_valid,
  output logic         out1_valid,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [8:0] MAX_BURST_W = 9'(MAX_BURST);

  state_t               state_q, state_d;
  logic                 rr_last_q, rr_last_d;
  logic [7:0]           burst_cnt_q, burst_cnt_d;
  logic [8:0]           cnt_inc;
  logic [NUM_DELAY-1:0] vld_q, vld_d, tag_q, tag_d;

  logic         grant_vld;
  logic         grant_id;
  logic         sel_valid;
  logic         sel_last;
  logic [N-1:0] sel_data;
  logic         accept;

  // Grant selection: IDLE arbitrates among live requests, OWNk holds k.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          grant_vld = 1'b1;
          grant_id  = ~rr_last_q;
        end else if (req0_valid) begin
          grant_vld = 1'b1;
          grant_id  = 1'b0;
        end else if (req1_valid) begin
          grant_vld = 1'b1;
          grant_id  = 1'b1;
        end
      end
      OWN0: begin
        grant_vld = 1'b1;
        grant_id  = 1'b0;
      end
      OWN1: begin
        grant_vld = 1'b1;
        grant_id  = 1'b1;
      end
      default: begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
      end
    endcase
  end

  assign req0_ready = grant_vld & ~grant_id;
  assign req1_ready = grant_vld & grant_id;
  assign sel_valid  = grant_id ? req1_valid : req0_valid;
  assign sel_last   = grant_id ? req1_last  : req0_last;
  assign sel_data   = grant_id ? req1_data  : req0_data;
  assign accept     = grant_vld & sel_valid;
  assign dl_in      = accept ? sel_data : '0;
  assign cnt_inc    = {1'b0, burst_cnt_q} + 9'd1;

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!sel_last && (cnt_inc < MAX_BURST_W)) begin
            state_d     = grant_id ? OWN1 : OWN0;
            burst_cnt_d = cnt_inc[7:0];
          end else begin
            rr_last_d   = grant_id;
            burst_cnt_d = '0;
          end
        end
      end
      OWN0, OWN1: begin
        // A dropped valid releases the grant immediately rather than holding a bubble.
        if (!sel_valid || sel_last || (cnt_inc == MAX_BURST_W)) begin
          state_d     = IDLE;
          rr_last_d   = grant_id;
          burst_cnt_d = '0;
        end else begin
          burst_cnt_d = cnt_inc[7:0];
        end
      end
      default: begin
        state_d     = IDLE;
        burst_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    vld_d    = vld_q << 1;
    tag_d    = tag_q << 1;
    vld_d[0] = accept;
    tag_d[0] = grant_id;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_last_q   <= 1'b1;
      burst_cnt_q <= '0;
      vld_q       <= '0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      burst_cnt_q <= burst_cnt_d;
      vld_q       <= vld_d;
      tag_q       <= tag_d;
    end
  end

  assign out_data   = dl_out;
  assign out0_valid = vld_q[NUM_DELAY-1] & ~tag_q[NUM_DELAY-1];
  assign out1_valid = vld_q[NUM_DELAY-1] &  tag_q[NUM_DELAY-1];
  assign busy       = (state_q != IDLE) | (|vld_q);

endmodule
